// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the CORDIC vectoring controller.
//   - state_t      : controller FSM states
//   - Q_PP..Q_NN   : quadrant codes {x<0, y<0} handed to the angle converter
//   - *_DEF        : default widths
//   - quadrant_of  : builds the quadrant code from the input sign bits
package cordic_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned CORDIC_STEPS_DEF = 16;
  localparam int unsigned ANGLE_W_DEF      = 16;

  localparam logic [1:0] Q_PP = 2'b00;  // x>=0, y>=0
  localparam logic [1:0] Q_PN = 2'b01;  // x>=0, y<0
  localparam logic [1:0] Q_NP = 2'b10;  // x<0,  y>=0
  localparam logic [1:0] Q_NN = 2'b11;  // x<0,  y<0

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    CONV = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Quadrant code from the sign bits of the raw input sample
  function automatic logic [1:0] quadrant_of(input logic x_neg, input logic y_neg);
    if (x_neg) return y_neg ? Q_NN : Q_NP;
    else       return y_neg ? Q_PN : Q_PP;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational CORDIC vectoring micro-rotation.
// Ports:
//   xr, yr     in  current (signed) vector
//   idx        in  step index i, used as the arithmetic shift amount
//   xr_next_c  out next x
//   yr_next_c  out next y
//   dir_c      out direction bit (1 when yr >= 0)
module cordic_vec_stage #(
  parameter int unsigned XW = 18,
  parameter int unsigned IW = 4
) (
  input  logic signed [XW-1:0] xr,
  input  logic signed [XW-1:0] yr,
  input  logic        [IW-1:0] idx,
  output logic signed [XW-1:0] xr_next_c,
  output logic signed [XW-1:0] yr_next_c,
  output logic                 dir_c
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  // Shift-add on the old values; truncating arithmetic shifts, no rounding
  always_comb begin
    xs    = xr >>> idx;
    ys    = yr >>> idx;
    dir_c = ~yr[XW-1];
    if (dir_c) begin
      xr_next_c = xr + ys;
      yr_next_c = yr - xs;
    end else begin
      xr_next_c = xr - ys;
      yr_next_c = yr + xs;
    end
  end

endmodule

// File: rtl/cordic_vectoring_ctrl.sv
// cordic_vectoring_ctrl: sequences one CORDIC vectoring operation per request.
// Folds (in_x, in_y) into the right half-plane, runs CORDIC_STEPS micro-rotations
// (one per clock), hands quadrant + direction vector to the angle converter,
// waits for conv_done, then presents angle and unscaled magnitude.
// Optional feature macro: CORDIC_CTRL_ZERO_BYPASS_EN (a (0,0) sample goes straight
// to OUT with angle 0 / magnitude 0 and no converter pulse).
// Ports:
//   clk, nreset                 clock, async active-low reset
//   in_valid/in_ready, in_x/y   input sample handshake
//   conv_enable                 one-cycle start pulse to the converter
//   conv_quadrant               quadrant code, held until the next accept
//   conv_micro_rotation         direction vector, bit i = step i
//   conv_done, conv_angle       converter result
//   out_valid/out_ready         result handshake
//   out_angle, out_mag          signed angle, final x (includes CORDIC gain)
module cordic_vectoring_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CORDIC_STEPS = CORDIC_STEPS_DEF,
  parameter int unsigned ANGLE_W      = ANGLE_W_DEF
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_x,
  input  logic [DATA_W-1:0]       in_y,
  output logic                    conv_enable,
  output logic [1:0]              conv_quadrant,
  output logic [CORDIC_STEPS-1:0] conv_micro_rotation,
  input  logic                    conv_done,
  input  logic [ANGLE_W-1:0]      conv_angle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ANGLE_W-1:0]      out_angle,
  output logic [DATA_W+1:0]       out_mag
);

  localparam int unsigned XW = DATA_W + 2;
  localparam int unsigned IW = (CORDIC_STEPS > 1) ? $clog2(CORDIC_STEPS) : 1;
  localparam logic [IW-1:0] LAST_STEP = IW'(CORDIC_STEPS - 1);

  state_t state, state_n;

  logic signed [XW-1:0]     xr, yr, xr_n, yr_n;
  logic        [IW-1:0]     cnt, cnt_n;
  logic [CORDIC_STEPS-1:0]  micro_n;
  logic [1:0]               quad_n;
  logic [ANGLE_W-1:0]       angle_n;
  logic [XW-1:0]            mag_n;
  logic                     in_ready_n, out_valid_n, conv_enable_n;

  logic signed [XW-1:0]     in_x_ext, in_y_ext;
  logic signed [XW-1:0]     st_x_c, st_y_c;
  logic                     st_dir_c;

  // Widen before negation so the most negative input folds exactly
  assign in_x_ext = XW'($signed(in_x));
  assign in_y_ext = XW'($signed(in_y));

  cordic_vec_stage #(
    .XW (XW),
    .IW (IW)
  ) u_stage (
    .xr        (xr),
    .yr        (yr),
    .idx       (cnt),
    .xr_next_c (st_x_c),
    .yr_next_c (st_y_c),
    .dir_c     (st_dir_c)
  );

  // Next-state and next-register logic
  always_comb begin
    state_n = state;
    xr_n    = xr;
    yr_n    = yr;
    cnt_n   = cnt;
    micro_n = conv_micro_rotation;
    quad_n  = conv_quadrant;
    angle_n = out_angle;
    mag_n   = out_mag;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          quad_n  = quadrant_of(in_x[DATA_W-1], in_y[DATA_W-1]);
          xr_n    = in_x_ext[XW-1] ? -in_x_ext : in_x_ext;
          yr_n    = in_y_ext[XW-1] ? -in_y_ext : in_y_ext;
          cnt_n   = '0;
          micro_n = '0;
          state_n = ITER;
`ifdef CORDIC_CTRL_ZERO_BYPASS_EN
          if ((in_x == '0) && (in_y == '0)) begin
            angle_n = '0;
            mag_n   = '0;
            state_n = OUT;
          end
`endif
        end
      end
      ITER: begin
        xr_n         = st_x_c;
        yr_n         = st_y_c;
        micro_n[cnt] = st_dir_c;
        cnt_n        = cnt + IW'(1);
        if (cnt == LAST_STEP) state_n = CONV;
      end
      CONV: state_n = WAIT;
      WAIT: begin
        if (conv_done) begin
          angle_n = conv_angle;
          mag_n   = xr;
          state_n = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Handshake/strobe flops track the state being entered
    in_ready_n    = (state_n == IDLE);
    out_valid_n   = (state_n == OUT);
    conv_enable_n = (state_n == CONV);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state               <= IDLE;
      xr                  <= '0;
      yr                  <= '0;
      cnt                 <= '0;
      conv_micro_rotation <= '0;
      conv_quadrant       <= '0;
      out_angle           <= '0;
      out_mag             <= '0;
      in_ready            <= 1'b0;
      out_valid           <= 1'b0;
      conv_enable         <= 1'b0;
    end else begin
      state               <= state_n;
      xr                  <= xr_n;
      yr                  <= yr_n;
      cnt                 <= cnt_n;
      conv_micro_rotation <= micro_n;
      conv_quadrant       <= quad_n;
      out_angle           <= angle_n;
      out_mag             <= mag_n;
      in_ready            <= in_ready_n;
      out_valid           <= out_valid_n;
      conv_enable         <= conv_enable_n;
    end
  end

endmodule
